// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the DataMemory port.
// Turns RV32I byte/half/word load/store requests into word-wide MRd/MWrt
// accesses. Sub-word stores are read-modify-write since DataMemory has no
// byte enables. All outputs are registered.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// H/HU/W accesses return RSP_ERR without touching memory; when undefined the
// offending low address bits are forced to zero and the access proceeds.
module load_store_unit #(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              MRd,
  output logic              MWrt,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [31:0]       M_WDATA,
  input  logic [31:0]       M_RDATA
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} state_t;

  // only what is needed after the accept edge; the word address lives in M_ADDR
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_RD_LAT - 1);

  state_t            state, nxt_state;
  req_t              req_q, nxt_req;
  logic [1:0]        cnt, nxt_cnt;
  logic              nxt_req_ready, nxt_rsp_valid, nxt_rsp_err, nxt_mrd, nxt_mwrt;
  logic [31:0]       nxt_rsp_rdata, nxt_m_wdata;
  logic [ADDR_W-1:0] nxt_m_addr, req_waddr;
  logic              illegal, misalign;
  logic [1:0]        req_lane;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_data, merged;

  assign illegal   = (REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3 == 3'b110) ||
                     (REQ_FUNCT3 == 3'b111) || (REQ_WE && REQ_FUNCT3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign  = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                     ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
`else
  assign misalign  = 1'b0;
`endif
  assign req_waddr = {2'b00, REQ_ADDR[ADDR_W-1:2]};
  assign ld_b      = M_RDATA[{req_q.lane, 3'b000} +: 8];
  assign ld_h      = M_RDATA[{req_q.lane[1], 4'b0000} +: 16];

  // lane within the word, with natural alignment forced for H/W
  always_comb begin
    req_lane = REQ_ADDR[1:0];
    case (REQ_FUNCT3[1:0])
      2'b01:   req_lane = {REQ_ADDR[1], 1'b0};
      2'b10:   req_lane = 2'b00;
      default: req_lane = REQ_ADDR[1:0];
    endcase
  end

  // load extension and store merge from the captured memory word
  always_comb begin
    ld_data = M_RDATA;
    merged  = M_RDATA;
    case (req_q.funct3)
      3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
      3'b100:  ld_data = {24'h0, ld_b};
      3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
      3'b101:  ld_data = {16'h0, ld_h};
      default: ld_data = M_RDATA;
    endcase
    if (req_q.funct3[0]) merged[{req_q.lane[1], 4'b0000} +: 16] = req_q.wdata;
    else                 merged[{req_q.lane, 3'b000} +: 8]      = req_q.wdata[7:0];
  end

  // next state and next registered outputs
  always_comb begin
    nxt_state     = state;
    nxt_req       = req_q;
    nxt_cnt       = cnt;
    nxt_req_ready = REQ_READY;
    nxt_rsp_valid = RSP_VALID;
    nxt_rsp_rdata = RSP_RDATA;
    nxt_rsp_err   = RSP_ERR;
    nxt_mrd       = 1'b0;
    nxt_mwrt      = 1'b0;
    nxt_m_addr    = M_ADDR;
    nxt_m_wdata   = M_WDATA;
    case (state)
      IDLE: begin
        nxt_req_ready = 1'b1;
        if (REQ_VALID && REQ_READY) begin
          nxt_req_ready = 1'b0;
          nxt_req       = '{we: REQ_WE, funct3: REQ_FUNCT3, lane: req_lane, wdata: REQ_WDATA[15:0]};
          if (illegal || misalign) begin
            nxt_state     = RESP;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_err   = 1'b1;
            nxt_rsp_rdata = 32'h0;
          end else if (REQ_WE && (REQ_FUNCT3 == 3'b010)) begin
            nxt_state   = WR;
            nxt_mwrt    = 1'b1;
            nxt_m_addr  = req_waddr;
            nxt_m_wdata = REQ_WDATA;
          end else begin
            nxt_state  = RD;
            nxt_mrd    = 1'b1;
            nxt_m_addr = req_waddr;
          end
        end
      end
      RD: begin
        nxt_state = WAIT;
        nxt_cnt   = 2'd0;
      end
      WAIT: begin
        if (cnt == WAIT_LAST) begin
          if (req_q.we) begin
            nxt_state   = WR;
            nxt_mwrt    = 1'b1;
            nxt_m_wdata = merged;
          end else begin
            nxt_state     = RESP;
            nxt_rsp_valid = 1'b1;
            nxt_rsp_err   = 1'b0;
            nxt_rsp_rdata = ld_data;
          end
        end else begin
          nxt_cnt = cnt + 2'd1;
        end
      end
      WR: begin
        nxt_state     = RESP;
        nxt_rsp_valid = 1'b1;
        nxt_rsp_err   = 1'b0;
        nxt_rsp_rdata = 32'h0;
      end
      RESP: begin
        if (RSP_READY) begin
          nxt_rsp_valid = 1'b0;
          nxt_state     = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // state and output registers; reset aborts any access in flight
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      req_q     <= '0;
      cnt       <= 2'd0;
      REQ_READY <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 32'h0;
      RSP_ERR   <= 1'b0;
      MRd       <= 1'b0;
      MWrt      <= 1'b0;
      M_ADDR    <= '0;
      M_WDATA   <= 32'h0;
    end else begin
      state     <= nxt_state;
      req_q     <= nxt_req;
      cnt       <= nxt_cnt;
      REQ_READY <= nxt_req_ready;
      RSP_VALID <= nxt_rsp_valid;
      RSP_RDATA <= nxt_rsp_rdata;
      RSP_ERR   <= nxt_rsp_err;
      MRd       <= nxt_mrd;
      MWrt      <= nxt_mwrt;
      M_ADDR    <= nxt_m_addr;
      M_WDATA   <= nxt_m_wdata;
    end
  end

endmodule
